// File: rtl/bus2_pkg.sv
// Shared bus2 definitions: command encoding, arbiter FSM states and the
// bus geometry defaults also used by the caches and the memory controller.
package bus2_pkg;

  localparam int ADDR2_W_DEF    = 15;
  localparam int DATA_W_DEF     = 16;
  localparam int LINE_BEATS_DEF = 8;

  typedef enum logic [1:0] {
    C2_NOP        = 2'd0,
    C2_RESPONSE   = 2'd1,
    C2_READ_LINE  = 2'd2,
    C2_WRITE_LINE = 2'd3
  } mem_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_WAIT_RESP,
    S_RDATA,
    S_DONE
  } state_t;

  // One-hot strobe for a 1-bit port id (bit 0 = icache, bit 1 = dcache).
  function automatic logic [1:0] port_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a contest the port that did not win last
// time gets the grant; rr_last resets to 1 so port 0 wins the first contest.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,   // commit the current grant as the new rr_last
  output logic       gnt_id,
  output logic       gnt_vld
);

  logic rr_last_q, rr_last_d;

  // Winner selection and rr_last update.
  always_comb begin
    gnt_vld   = |req;
    gnt_id    = (req == 2'b11) ? ~rr_last_q : req[1];
    rr_last_d = (update && gnt_vld) ? gnt_id : rr_last_q;
  end

  // rr_last register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= 1'b1;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/bus2_arbiter.sv
// bus2 arbiter: shares the cache-to-memory line bus between the icache
// (port 0) and the dcache (port 1), sequencing command, write beats,
// response wait with timeout, and registered read beats.
module bus2_arbiter
  import bus2_pkg::*;
#(
  parameter int ADDR2_W    = ADDR2_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR2_W-1:0]  req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_wbeat_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_last,
  output logic [1:0]            done,
  output logic                  err,
  output logic                  proto_err,
  output logic [1:0]            mem_cmd,
  output logic [ADDR2_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp,
  output logic                  busy,
  output logic                  grant_id
);

  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic [ADDR2_W-1:0]  addr_q, addr_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic                rsp_last_q, rsp_last_d;
  logic                proto_err_q, proto_err_d;

  logic                arb_update, arb_id, arb_vld;
  logic                wbeat;
  logic [1:0]          done_o;
  logic                err_o;
  logic [DATA_W-1:0]   wdata_sel;
  mem_cmd_t            cmd;

  rr_arbiter2 u_rr (
    .clk     (CLK),
    .rst     (RESET),
    .req     (req_valid),
    .update  (arb_update),
    .gnt_id  (arb_id),
    .gnt_vld (arb_vld)
  );

  // Current write beat of the granted requester.
  always_comb begin
    wdata_sel = grant_q ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
  end

  // Transaction sequencer: next state, datapath updates and bus outputs.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    write_d     = write_q;
    beat_d      = beat_q;
    to_d        = '0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_vld_d   = 1'b0;
    rsp_last_d  = 1'b0;
    // A response is only legal while waiting for one; anything else is sticky.
    proto_err_d = proto_err_q | (mem_resp && (state_q != S_WAIT_RESP));
    cmd         = C2_NOP;
    mem_addr    = '0;
    mem_wdata   = '0;
    wbeat       = 1'b0;
    done_o      = 2'b00;
    err_o       = 1'b0;
    arb_update  = 1'b0;

    case (state_q)
      S_IDLE: begin
        arb_update = 1'b1;
        if (arb_vld) begin
          grant_d = arb_id;
          addr_d  = arb_id ? req_addr[2*ADDR2_W-1:ADDR2_W] : req_addr[ADDR2_W-1:0];
          write_d = req_write[arb_id];
          err_d   = 1'b0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        mem_addr = addr_q;
        beat_d   = '0;
        if (write_q) begin
          // The command cycle doubles as write beat 0.
          cmd       = C2_WRITE_LINE;
          wbeat     = 1'b1;
          mem_wdata = wdata_sel;
          if (LINE_BEATS == 1) begin
            state_d = S_WAIT_RESP;
          end else begin
            beat_d  = CNT_W'(1);
            state_d = S_WDATA;
          end
        end else begin
          cmd     = C2_READ_LINE;
          state_d = S_WAIT_RESP;
        end
      end
      S_WDATA: begin
        wbeat     = 1'b1;
        mem_wdata = wdata_sel;
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_WAIT_RESP;
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      S_WAIT_RESP: begin
        if (mem_resp) begin
          if (write_q) begin
            state_d = S_DONE;
          end else begin
            // Read beat 0 rides on the response cycle.
            rdata_d    = mem_rdata;
            rsp_vld_d  = 1'b1;
            rsp_last_d = (LINE_BEATS == 1);
            beat_d     = '0;
            state_d    = S_RDATA;
          end
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_RDATA: begin
        // beat_q is the beat currently presented; capture the next one.
        if (beat_q == LAST_BEAT) begin
          state_d = S_DONE;
        end else begin
          rdata_d    = mem_rdata;
          rsp_vld_d  = 1'b1;
          rsp_last_d = ((beat_q + CNT_W'(1)) == LAST_BEAT);
          beat_d     = beat_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        done_o  = port_onehot(grant_q);
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any transaction silently.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      grant_q     <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      beat_q      <= '0;
      to_q        <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      beat_q      <= beat_d;
      to_q        <= to_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_last_q  <= rsp_last_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Port-facing outputs.
  always_comb begin
    mem_cmd         = cmd;
    req_wbeat_ready = wbeat ? port_onehot(grant_q) : 2'b00;
    rsp_valid       = rsp_vld_q ? port_onehot(grant_q) : 2'b00;
    rsp_rdata       = rdata_q;
    rsp_last        = rsp_last_q;
    done            = done_o;
    err             = err_o;
    proto_err       = proto_err_q;
    busy            = (state_q != S_IDLE);
    grant_id        = grant_q;
  end

endmodule

// File: tb/tb_bus2_arbiter.sv
// Bench for bus2_arbiter: table of directed transactions, hand sequences for
// reset/stray-response corners, then random transactions checked against a
// cycle-schedule model derived from the latency and round-robin rules.
module tb_bus2_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int LB = 8;
  localparam int TO = 255;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [1:0]    req_valid, req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]    req_wbeat_ready, rsp_valid, done, mem_cmd;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic          rsp_last, err, proto_err, mem_resp, busy, grant_id;
  logic [AW-1:0] mem_addr;

  bus2_arbiter #(.ADDR2_W(AW), .DATA_W(DW), .LINE_BEATS(LB), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wbeat_ready(req_wbeat_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
    .done(done), .err(err), .proto_err(proto_err),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]    req;
    logic [1:0]    wr;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] rbase, wbase;
    int            r;          // memory wait cycles after the last command/write beat
    bit            nresp;      // memory never answers
    int            stray;      // cycle index of an extra mem_resp (0 = none)
    int            exp_grant;
    int            exp_done;   // cycle of done, grant cycle = 0
  } txn_t;

  int  checks = 0, failures = 0;
  bit  m_rr = 1'b1;     // port that won the last contest
  bit  m_perr = 1'b0;   // expected sticky protocol error
  txn_t tbl[7];
  txn_t t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Runs one transaction; cycle c counts from the grant cycle (c=0).
  task automatic run_txn(input txn_t x, input int abort_at);
    int g, rc, dc, wi, rdy;
    bit w;
    logic [1:0] oh;
    g  = x.exp_grant;
    w  = x.wr[g];
    oh = (g == 1) ? 2'b10 : 2'b01;
    rc = (w ? LB : 1) + 1 + x.r;
    dc = x.exp_done;
    wi = 0;
    rdy = 0;
    @(negedge CLK);
    req_valid = x.req; req_write = x.wr; req_addr = {x.a1, x.a0};
    req_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_perr", proto_err, m_perr);
    for (int c = 1; c <= dc; c++) begin
      @(negedge CLK);
      mem_resp  = (!x.nresp && c == rc) || (c == x.stray);
      mem_rdata = (!w && c >= rc && c < rc + LB) ? x.rbase + DW'(c - rc) : '0;
      req_wdata = '0;
      if (g == 1) req_wdata[2*DW-1:DW] = x.wbase + DW'(wi);
      else        req_wdata[DW-1:0]    = x.wbase + DW'(wi);
      #1;
      chk("mem_cmd", mem_cmd, (c == 1) ? (w ? 3 : 2) : 0);
      if (c == 1) begin
        chk("mem_addr", mem_addr, g ? x.a1 : x.a0);
        chk("grant_id", grant_id, g);
      end
      chk("busy", busy, 1);
      if (!w && !x.nresp && c > rc && c <= rc + LB) begin
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_rdata", rsp_rdata, x.rbase + DW'(c - rc - 1));
        chk("rsp_last", rsp_last, c == rc + LB);
      end else begin
        chk("rsp_valid", rsp_valid, 0);
        chk("rsp_last", rsp_last, 0);
      end
      chk("done", done, (c == dc) ? oh : 2'b00);
      chk("err", err, (c == dc) && x.nresp);
      chk("proto_err", proto_err, m_perr || (x.stray != 0 && c > x.stray));
      if (w && c <= LB) chk("mem_wdata", mem_wdata, x.wbase + DW'(c - 1));
      chk("ready_other", req_wbeat_ready[1-g], 0);
      if (req_wbeat_ready[g]) begin
        rdy++;
        wi++;
      end
      if (c == abort_at) begin
        RESET = 1'b1;
        #1;
        chk("rst_outs", {rsp_valid, rsp_last, done, err, busy, mem_cmd,
                         grant_id, req_wbeat_ready, proto_err}, 0);
        chk("rst_data", {rsp_rdata, mem_wdata}, 0);
        chk("rst_addr", mem_addr, 0);
        m_rr = 1'b1;
        m_perr = 1'b0;
        return;
      end
    end
    chk("ready_cnt", rdy, w ? LB : 0);
    if (x.stray != 0) m_perr = 1'b1;
    m_rr = (g == 1);
  endtask

  initial begin
    //        req    wr     a0        a1        rbase     wbase     r  nresp stray grant done
    tbl[0] = '{2'b01, 2'b00, 15'h1234, 15'h0000, 16'h0100, 16'h0000, 5, 0, 0,   0, 16};
    tbl[1] = '{2'b10, 2'b10, 15'h0000, 15'h0042, 16'h0000, 16'hA000, 2, 0, 0,   1, 12};
    tbl[2] = '{2'b11, 2'b00, 15'h0111, 15'h0222, 16'h2000, 16'h0000, 0, 0, 0,   0, 11};
    tbl[3] = '{2'b11, 2'b11, 15'h0333, 15'h0444, 16'h0000, 16'h3000, 1, 0, 0,   1, 11};
    tbl[4] = '{2'b11, 2'b01, 15'h0555, 15'h0556, 16'h4400, 16'h4000, 3, 0, 0,   0, 13};
    tbl[5] = '{2'b11, 2'b00, 15'h0665, 15'h0666, 16'h0000, 16'h0000, 0, 1, 257, 1, 257};
    tbl[6] = '{2'b01, 2'b00, 15'h0777, 15'h0000, 16'h7000, 16'h0000, 0, 0, 0,   0, 11};

    RESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_outs", {rsp_valid, rsp_last, done, err, busy, mem_cmd,
                       grant_id, req_wbeat_ready, proto_err}, 0);
    chk("reset_data", {rsp_rdata, mem_wdata}, 0);
    RESET = 1'b0;

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 0);

    // Reset while read beat 3 is on rsp_rdata (r=0: beat 0 shown at cycle 3).
    t = '{2'b01, 2'b00, 15'h0123, 15'h0000, 16'h5000, 16'h0000, 0, 0, 0, 0, 11};
    run_txn(t, 6);
    repeat (2) @(negedge CLK);
    req_valid = '0; mem_resp = 1'b0; mem_rdata = '0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      #1 chk("post_rst", {done, busy, proto_err, rsp_valid}, 0);
    end

    // Contest straight after reset: port 0 first, then port 1.
    t = '{2'b11, 2'b00, 15'h0010, 15'h0020, 16'h6000, 16'h0000, 1, 0, 0, 0, 12};
    run_txn(t, 0);
    t = '{2'b11, 2'b10, 15'h0030, 15'h0040, 16'h0000, 16'h6100, 0, 0, 0, 1, 10};
    run_txn(t, 0);

    // Stray response while idle.
    @(negedge CLK);
    req_valid = '0; mem_resp = 1'b1;
    @(negedge CLK);
    mem_resp = 1'b0;
    #1;
    chk("stray_idle", {rsp_valid, done, busy}, 0);
    chk("stray_perr", proto_err, 1);
    m_perr = 1'b1;

    // Random transactions against the schedule model; proto_err must stay set.
    for (int i = 0; i < 20; i++) begin
      t.req   = 2'($urandom_range(1, 3));
      t.wr    = 2'($urandom_range(0, 3));
      t.a0    = AW'($urandom);
      t.a1    = AW'($urandom);
      t.rbase = DW'($urandom);
      t.wbase = DW'($urandom);
      t.r     = $urandom_range(0, 6);
      t.nresp = 1'b0;
      t.stray = 0;
      t.exp_grant = (t.req == 2'b11) ? int'(!m_rr) : int'(t.req[1]);
      t.exp_done  = t.wr[t.exp_grant] ? LB + 2 + t.r : LB + 3 + t.r;
      run_txn(t, 0);
    end

    @(negedge CLK);
    req_valid = '0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("perr_cleared", proto_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
